// File: rtl/ref_broadcast_ctrl.sv
// Reference-particle broadcast sequencer for one home cell: latches the cell's
// particle count, issues IDs 1..count on a ready handshake, drains, then pulses done.
module ref_broadcast_ctrl #(
  parameter int unsigned PARTICLE_ID_WIDTH = 7,
  parameter int unsigned DRAIN_CYCLES      = 3,
  parameter int unsigned CNT_TIMEOUT       = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [PARTICLE_ID_WIDTH-1:0] particle_count,
  input  logic                         count_valid,
  input  logic                         filter_ready,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
  output logic                         ref_valid,
  output logic                         broadcast_done,
  output logic                         busy
);

  localparam int unsigned ID_W    = PARTICLE_ID_WIDTH;
  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned TO_W    = (CNT_TIMEOUT > 1) ? $clog2(CNT_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_CNT = 2'd1,
    BCAST    = 2'd2,
    DRAIN    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ref_id_q, ref_id_d;
  logic                ref_valid_q, ref_valid_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [ID_W-1:0]     count_q, count_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [TO_W-1:0]     tmo_q, tmo_d;

  logic handshake;
  logic last_ref;
  logic tmo_hit;

  assign handshake = ref_valid_q & filter_ready;
  // Equality stop keeps a full-scale count (all ones) from ever wrapping ref_id.
  assign last_ref  = (ref_id_q == count_q);
  assign tmo_hit   = (CNT_TIMEOUT != 0) && (tmo_q == TO_W'(CNT_TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = WAIT_CNT;
      end
      WAIT_CNT: begin
        if (count_valid) begin
          state_d = (particle_count != '0) ? BCAST : DRAIN;
        end else if (tmo_hit) begin
          state_d = DRAIN;
        end
      end
      BCAST: begin
        if (handshake && last_ref) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    ref_id_d    = ref_id_q;
    ref_valid_d = ref_valid_q;
    done_d      = 1'b0;
    busy_d      = (state_d != IDLE);
    count_d     = count_q;
    drain_d     = drain_q;
    tmo_d       = tmo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          tmo_d    = '0;
          count_d  = '0;
          ref_id_d = '0;
        end
      end
      WAIT_CNT: begin
        if (count_valid) begin
          count_d = particle_count;
          if (particle_count != '0) begin
            ref_id_d    = ID_W'(1);
            ref_valid_d = 1'b1;
          end else begin
            drain_d = DRAIN_W'(DRAIN_CYCLES);
          end
        end else if (tmo_hit) begin
          count_d = '0;
          drain_d = DRAIN_W'(DRAIN_CYCLES);
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      BCAST: begin
        if (handshake) begin
          if (last_ref) begin
            ref_valid_d = 1'b0;
            drain_d     = DRAIN_W'(DRAIN_CYCLES);
          end else begin
            ref_id_d = ref_id_q + ID_W'(1);
          end
        end
      end
      DRAIN: begin
        // Done fires on the cycle the counter lands on zero; IDLE follows one cycle later.
        if (drain_q != '0) begin
          drain_d = drain_q - DRAIN_W'(1);
          done_d  = (drain_q == DRAIN_W'(1));
        end
      end
      default: begin
        ref_valid_d = 1'b0;
      end
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_id_q    <= '0;
      ref_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
      drain_q     <= '0;
      tmo_q       <= '0;
    end else begin
      ref_id_q    <= ref_id_d;
      ref_valid_q <= ref_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      count_q     <= count_d;
      drain_q     <= drain_d;
      tmo_q       <= tmo_d;
    end
  end

  assign ref_id         = ref_id_q;
  assign ref_valid      = ref_valid_q;
  assign broadcast_done = done_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_ref_broadcast_ctrl.sv
// Directed bench for ref_broadcast_ctrl: one task per scenario with inline checks.
module tb_ref_broadcast_ctrl;

  localparam int unsigned PW = 7;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [PW-1:0] particle_count;
  logic          count_valid;
  logic          filter_ready;
  logic [PW-1:0] ref_id;
  logic          ref_valid;
  logic          broadcast_done;
  logic          busy;

  int n_checks;
  int n_pass;

  int hs_ids[$];
  int done_cnt, done_i, idle_i, first_hs_i, last_hs_i, hold_err, refv_seen, finished;

  ref_broadcast_ctrl #(
    .PARTICLE_ID_WIDTH(PW),
    .DRAIN_CYCLES(3),
    .CNT_TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .particle_count(particle_count),
    .count_valid(count_valid),
    .filter_ready(filter_ready),
    .ref_id(ref_id),
    .ref_valid(ref_valid),
    .broadcast_done(broadcast_done),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pulse start, wait `delay` cycles in WAIT_CNT, then present count_valid (sampled at the next edge).
  task automatic start_cell(input int delay, input int cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int d = 0; d < delay; d++) tick();
    count_valid    = 1'b1;
    particle_count = PW'(cnt);
  endtask

  // Runs cycles, recording handshakes, done pulses and hold violations.
  // mode 0: ready always 1; mode 1: ready 1,0,0,... plus stray start/count_valid at i==4.
  task automatic collect(input int mode, input int budget);
    logic          fr, hs, pv;
    logic [PW-1:0] pid;
    hs_ids.delete();
    done_cnt = 0; done_i = -1; idle_i = -1; first_hs_i = -1; last_hs_i = -1;
    hold_err = 0; refv_seen = 0; finished = 0;
    for (int i = 0; i < budget; i++) begin
      fr = (mode == 0) ? 1'b1 : ((i % 3) == 0);
      filter_ready = fr;
      if (mode == 1 && i == 4) begin
        count_valid    = 1'b1;
        particle_count = PW'(2);
        start          = 1'b1;
      end
      hs  = ref_valid && fr;
      pid = ref_id;
      pv  = ref_valid;
      tick();
      count_valid = 1'b0;
      start       = 1'b0;
      if (hs) begin
        hs_ids.push_back(int'(pid));
        if (first_hs_i < 0) first_hs_i = i;
        last_hs_i = i;
      end
      if (pv && !fr && (ref_id !== pid || ref_valid !== 1'b1)) hold_err++;
      if (ref_valid) refv_seen = 1;
      if (broadcast_done) begin
        done_cnt++;
        if (done_i < 0) done_i = i;
      end
      if (done_cnt > 0 && !busy && idle_i < 0) idle_i = i;
      if (idle_i >= 0 && i >= idle_i + 2) begin
        finished = 1;
        break;
      end
    end
    filter_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; count_valid = 1'b0; particle_count = '0; filter_ready = 1'b0;
    tick(); tick();
    n_checks++; if (ref_id !== '0) $display("FAIL reset_ref_id: got %0d expected 0", ref_id); else n_pass++;
    n_checks++; if (ref_valid !== 1'b0) $display("FAIL reset_ref_valid: got %0b expected 0", ref_valid); else n_pass++;
    n_checks++; if (broadcast_done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", broadcast_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    start_cell(2, 5);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy_wait: got %0b expected 1", busy); else n_pass++;
    n_checks++; if (ref_valid !== 1'b0) $display("FAIL basic_valid_wait: got %0b expected 0", ref_valid); else n_pass++;
    collect(0, 40);
    n_checks++; if (finished !== 1) $display("FAIL basic_finished: got %0d expected 1", finished); else n_pass++;
    n_checks++; if (hs_ids.size() !== 5) $display("FAIL basic_hs_count: got %0d expected 5", hs_ids.size()); else n_pass++;
    for (int k = 0; k < hs_ids.size() && k < 5; k++) begin
      n_checks++; if (hs_ids[k] !== k + 1) $display("FAIL basic_id[%0d]: got %0d expected %0d", k, hs_ids[k], k + 1); else n_pass++;
    end
    n_checks++; if (first_hs_i !== 1) $display("FAIL basic_first_latency: got %0d expected 1", first_hs_i); else n_pass++;
    n_checks++; if (last_hs_i - first_hs_i !== 4) $display("FAIL basic_consecutive: got %0d expected 4", last_hs_i - first_hs_i); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL basic_done_count: got %0d expected 1", done_cnt); else n_pass++;
    n_checks++; if (done_i - last_hs_i !== 3) $display("FAIL basic_done_gap: got %0d expected 3", done_i - last_hs_i); else n_pass++;
    n_checks++; if (idle_i - done_i !== 1) $display("FAIL basic_busy_fall: got %0d expected 1", idle_i - done_i); else n_pass++;
  endtask

  task automatic test_backpressure;
    start_cell(0, 4);
    collect(1, 60);
    n_checks++; if (hs_ids.size() !== 4) $display("FAIL bp_hs_count: got %0d expected 4", hs_ids.size()); else n_pass++;
    for (int k = 0; k < hs_ids.size() && k < 4; k++) begin
      n_checks++; if (hs_ids[k] !== k + 1) $display("FAIL bp_id[%0d]: got %0d expected %0d", k, hs_ids[k], k + 1); else n_pass++;
    end
    n_checks++; if (hold_err !== 0) $display("FAIL bp_hold: got %0d violations expected 0", hold_err); else n_pass++;
    n_checks++; if (last_hs_i !== 12) $display("FAIL bp_last_hs_cycle: got %0d expected 12", last_hs_i); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL bp_done_count: got %0d expected 1", done_cnt); else n_pass++;
    n_checks++; if (done_i !== 15) $display("FAIL bp_done_cycle: got %0d expected 15", done_i); else n_pass++;
  endtask

  task automatic test_empty_cell;
    start_cell(0, 0);
    collect(0, 30);
    n_checks++; if (refv_seen !== 0) $display("FAIL empty_ref_valid: got %0d expected 0", refv_seen); else n_pass++;
    n_checks++; if (hs_ids.size() !== 0) $display("FAIL empty_hs_count: got %0d expected 0", hs_ids.size()); else n_pass++;
    n_checks++; if (done_i !== 3) $display("FAIL empty_done_cycle: got %0d expected 3", done_i); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL empty_done_count: got %0d expected 1", done_cnt); else n_pass++;
  endtask

  task automatic test_timeout;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(0, 40);
    n_checks++; if (refv_seen !== 0) $display("FAIL tmo_ref_valid: got %0d expected 0", refv_seen); else n_pass++;
    n_checks++; if (done_i !== 17) $display("FAIL tmo_done_cycle: got %0d expected 17", done_i); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL tmo_done_count: got %0d expected 1", done_cnt); else n_pass++;
    n_checks++; if (idle_i - done_i !== 1) $display("FAIL tmo_busy_fall: got %0d expected 1", idle_i - done_i); else n_pass++;
  endtask

  task automatic test_full_scale;
    int bad;
    start_cell(0, 127);
    collect(0, 200);
    n_checks++; if (hs_ids.size() !== 127) $display("FAIL full_hs_count: got %0d expected 127", hs_ids.size()); else n_pass++;
    bad = 0;
    for (int k = 0; k < hs_ids.size(); k++) if (hs_ids[k] !== k + 1) bad++;
    n_checks++; if (bad !== 0) $display("FAIL full_id_order: got %0d out-of-order ids expected 0", bad); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL full_done_count: got %0d expected 1", done_cnt); else n_pass++;
    n_checks++; if (done_i - last_hs_i !== 3) $display("FAIL full_done_gap: got %0d expected 3", done_i - last_hs_i); else n_pass++;
  endtask

  task automatic test_reset_midop;
    int reached;
    reached = 0;
    start_cell(0, 6);
    filter_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      count_valid = 1'b0;
      if (ref_valid && ref_id == PW'(3)) begin
        reached = 1;
        break;
      end
    end
    n_checks++; if (reached !== 1) $display("FAIL midrst_reach_id3: got %0d expected 1", reached); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ref_id !== '0) $display("FAIL midrst_ref_id: got %0d expected 0", ref_id); else n_pass++;
    n_checks++; if (ref_valid !== 1'b0) $display("FAIL midrst_ref_valid: got %0b expected 0", ref_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %0b expected 0", busy); else n_pass++;
    n_checks++; if (broadcast_done !== 1'b0) $display("FAIL midrst_done: got %0b expected 0", broadcast_done); else n_pass++;
    filter_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) $display("FAIL midrst_idle_after: got %0b expected 0", busy); else n_pass++;
    start_cell(0, 2);
    collect(0, 30);
    n_checks++; if (hs_ids.size() !== 2) $display("FAIL midrst_hs_count: got %0d expected 2", hs_ids.size()); else n_pass++;
    for (int k = 0; k < hs_ids.size() && k < 2; k++) begin
      n_checks++; if (hs_ids[k] !== k + 1) $display("FAIL midrst_id[%0d]: got %0d expected %0d", k, hs_ids[k], k + 1); else n_pass++;
    end
    n_checks++; if (done_cnt !== 1) $display("FAIL midrst_done_count: got %0d expected 1", done_cnt); else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_cell();
    test_timeout();
    test_full_scale();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
